// File: rtl/bsg_manycore_fifo_mem_responder_if.sv
// ============================================================================
// Module : bsg_manycore_fifo_mem_responder_if
// Brief  : Request/response handshake bundle for the FIFO memory responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bsg_manycore_fifo_mem_responder_if #(
    parameter int FIFO_WIDTH_P = 128
);
    logic [FIFO_WIDTH_P-1:0] mc_req;
    logic                    mc_req_v;
    logic                    mc_req_ready;
    logic [FIFO_WIDTH_P-1:0] endpoint_rsp;
    logic                    endpoint_rsp_v;
    logic                    endpoint_rsp_ready;

    modport master (
        output mc_req, mc_req_v, endpoint_rsp_ready,
        input  mc_req_ready, endpoint_rsp, endpoint_rsp_v
    );

    modport slave (
        input  mc_req, mc_req_v, endpoint_rsp_ready,
        output mc_req_ready, endpoint_rsp, endpoint_rsp_v
    );
endinterface

`default_nettype wire

// File: rtl/bsg_manycore_fifo_mem_responder.sv
// ============================================================================
// Module : bsg_manycore_fifo_mem_responder
// Brief  : Services load/store/AMO request words against a local word memory
//          and returns one response word per request through a 2-entry FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bsg_manycore_fifo_mem_responder #(
    parameter int FIFO_WIDTH_P = 128,
    parameter int MEM_ELS_P    = 1024
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    bsg_manycore_fifo_mem_responder_if.slave        io_bus,
    output logic [31:0]                             req_count_o,
    output logic [31:0]                             err_count_o
);
    localparam int MEM_ADDR_WIDTH_LP = (MEM_ELS_P > 1) ? $clog2(MEM_ELS_P) : 1;

    localparam logic [7:0] c_OP_LOAD    = 8'd0;
    localparam logic [7:0] c_OP_STORE   = 8'd1;
    localparam logic [7:0] c_OP_AMOSWAP = 8'd2;
    localparam logic [7:0] c_OP_AMOADD  = 8'd3;
    localparam logic [7:0] c_RSP_DATA   = 8'd0;
    localparam logic [7:0] c_RSP_STORE  = 8'd1;
    localparam logic [7:0] c_RSP_ERR    = 8'd3;

    logic [31:0] r_mem [MEM_ELS_P];

    logic [FIFO_WIDTH_P-1:0] r_fifo [2];
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_count;
    logic [31:0]             r_req_count;
    logic [31:0]             r_err_count;

    logic [31:0]                  w_data;
    logic [31:0]                  w_addr;
    logic [7:0]                   w_op;
    logic [3:0]                   w_mask;
    logic [MEM_ADDR_WIDTH_LP-1:0] w_idx;
    logic [31:0]                  w_old;
    logic [31:0]                  w_wdata;
    logic [31:0]                  w_rdata;
    logic [7:0]                   w_type;
    logic                         w_we;
    logic                         w_err;
    logic                         w_full;
    logic                         w_accept;
    logic                         w_deq;
    logic [FIFO_WIDTH_P-1:0]      w_rsp;
    logic [FIFO_WIDTH_P-101:0]    w_unused_req_bits;

    assign w_data            = io_bus.mc_req[31:0];
    assign w_addr            = io_bus.mc_req[63:32];
    assign w_op              = io_bus.mc_req[71:64];
    assign w_mask            = io_bus.mc_req[75:72];
    assign w_unused_req_bits = io_bus.mc_req[FIFO_WIDTH_P-1:100];
    assign w_idx             = w_addr[MEM_ADDR_WIDTH_LP-1:0];
    assign w_old             = r_mem[w_idx];

    // Handshake: a full FIFO can still accept when its head leaves this cycle.
    assign w_full              = (r_count == 2'd2);
    assign io_bus.mc_req_ready = !reset_i &&
                                 (!w_full || (io_bus.endpoint_rsp_ready && io_bus.endpoint_rsp_v));
    assign w_accept            = io_bus.mc_req_v && io_bus.mc_req_ready;
    assign w_deq               = io_bus.endpoint_rsp_v && io_bus.endpoint_rsp_ready;

    assign io_bus.endpoint_rsp_v = (r_count != 2'd0);
    assign io_bus.endpoint_rsp   = io_bus.endpoint_rsp_v ? r_fifo[r_rd_ptr] : '0;
    assign req_count_o           = r_req_count;
    assign err_count_o           = r_err_count;

    always_comb begin
        w_err   = (w_op > c_OP_AMOADD) || (w_addr >= 32'(MEM_ELS_P));
        w_wdata = w_old;
        w_rdata = 32'd0;
        w_type  = c_RSP_DATA;
        w_we    = 1'b0;
        if (w_err) begin
            w_type = c_RSP_ERR;
        end else begin
            case (w_op)
                c_OP_LOAD: begin
                    w_rdata = w_old;
                end
                c_OP_STORE: begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_mask[b]) w_wdata[8*b +: 8] = w_data[8*b +: 8];
                    end
                    w_type = c_RSP_STORE;
                    w_we   = 1'b1;
                end
                c_OP_AMOSWAP: begin
                    w_rdata = w_old;
                    w_wdata = w_data;
                    w_we    = 1'b1;
                end
                c_OP_AMOADD: begin
                    w_rdata = w_old;
                    w_wdata = w_old + w_data;
                    w_we    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rsp        = '0;
        w_rsp[31:0]  = w_rdata;
        w_rsp[39:32] = w_type;
        w_rsp[47:40] = io_bus.mc_req[83:76];
        w_rsp[55:48] = io_bus.mc_req[91:84];
        w_rsp[63:56] = io_bus.mc_req[99:92];
    end

    // Memory is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk_i) begin
        if (w_accept && w_we) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_req_count <= 32'd0;
            r_err_count <= 32'd0;
        end else begin
            if (w_accept) begin
                r_fifo[r_wr_ptr] <= w_rsp;
                r_wr_ptr         <= ~r_wr_ptr;
                r_req_count      <= r_req_count + 32'd1;
                if (w_err) r_err_count <= r_err_count + 32'd1;
            end
            if (w_deq) r_rd_ptr <= ~r_rd_ptr;
            case ({w_accept, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_bsg_manycore_fifo_mem_responder.sv
// ============================================================================
// Module : tb_bsg_manycore_fifo_mem_responder
// Brief  : Directed, table-driven bench for the FIFO memory responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bsg_manycore_fifo_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_count;
    logic [31:0] err_count;
    int          n_pass = 0;
    int          n_total = 0;
    int          exp_req = 0;
    int          exp_err = 0;

    always #5 clk = ~clk;

    bsg_manycore_fifo_mem_responder_if #(.FIFO_WIDTH_P(128)) bus ();

    bsg_manycore_fifo_mem_responder #(
        .FIFO_WIDTH_P(128),
        .MEM_ELS_P   (1024)
    ) dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .io_bus     (bus),
        .req_count_o(req_count),
        .err_count_o(err_count)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [7:0]  exp_type;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [20];

    function automatic logic [127:0] mk_req(input logic [7:0] op, input logic [31:0] addr,
                                            input logic [31:0] data, input logic [3:0] mask,
                                            input logic [7:0] rid);
        logic [127:0] r;
        r          = '0;
        r[31:0]    = data;
        r[63:32]   = addr;
        r[71:64]   = op;
        r[75:72]   = mask;
        r[83:76]   = rid;
        r[91:84]   = rid + 8'h10;
        r[99:92]   = rid + 8'h20;
        r[127:100] = 28'hA5C3E17;
        return r;
    endfunction

    function automatic logic [127:0] mk_rsp(input logic [7:0] typ, input logic [31:0] data,
                                            input logic [7:0] rid);
        return {64'd0, rid + 8'h20, rid + 8'h10, rid, typ, data};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Entered just after a rising edge with an empty FIFO and rsp_ready=1.
    task automatic run_vec(input string name, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] mask, input logic [7:0] rid,
                           input logic [7:0] exp_type, input logic [31:0] exp_data);
        bus.mc_req   = mk_req(op, addr, data, mask, rid);
        bus.mc_req_v = 1'b1;
        @(negedge clk);
        check({name, "_ready"}, bus.mc_req_ready, 1);
        check({name, "_vpre"}, bus.endpoint_rsp_v, 0);
        @(posedge clk); #1;
        bus.mc_req_v = 1'b0;
        exp_req++;
        if (exp_type == 8'd3) exp_err++;
        @(negedge clk);
        check({name, "_v"}, bus.endpoint_rsp_v, 1);
        check({name, "_rsp"}, bus.endpoint_rsp, mk_rsp(exp_type, exp_data, rid));
        @(posedge clk); #1;
    endtask

    logic [127:0] q_req [4];
    logic [127:0] q_rsp [4];

    initial begin
        int  idx;
        int  outn;
        logic rdy;
        logic drove;

        vecs[0]  = '{8'd1, 32'd5,        32'hDEADBEEF, 4'hF, 8'd1, 32'd0};
        vecs[1]  = '{8'd0, 32'd5,        32'd0,        4'hF, 8'd0, 32'hDEADBEEF};
        vecs[2]  = '{8'd1, 32'd5,        32'h000000AA, 4'h1, 8'd1, 32'd0};
        vecs[3]  = '{8'd0, 32'd5,        32'd0,        4'h0, 8'd0, 32'hDEADBEAA};
        vecs[4]  = '{8'd1, 32'd9,        32'hFFFFFFFF, 4'hF, 8'd1, 32'd0};
        vecs[5]  = '{8'd1, 32'd9,        32'h11223344, 4'h5, 8'd1, 32'd0};
        vecs[6]  = '{8'd0, 32'd9,        32'd0,        4'h0, 8'd0, 32'hFF22FF44};
        vecs[7]  = '{8'd1, 32'd1023,     32'h12345678, 4'hF, 8'd1, 32'd0};
        vecs[8]  = '{8'd0, 32'd1023,     32'd0,        4'h0, 8'd0, 32'h12345678};
        vecs[9]  = '{8'd1, 32'd11,       32'hFFFFFFFF, 4'hF, 8'd1, 32'd0};
        vecs[10] = '{8'd3, 32'd11,       32'd2,        4'h0, 8'd0, 32'hFFFFFFFF};
        vecs[11] = '{8'd0, 32'd11,       32'd0,        4'h0, 8'd0, 32'h00000001};
        vecs[12] = '{8'd1, 32'd7,        32'd10,       4'hF, 8'd1, 32'd0};
        vecs[13] = '{8'd1, 32'd5,        32'd0,        4'h0, 8'd1, 32'd0};
        vecs[14] = '{8'd0, 32'd5,        32'd0,        4'h0, 8'd0, 32'hDEADBEAA};
        vecs[15] = '{8'd9, 32'd5,        32'h55,       4'hF, 8'd3, 32'd0};
        vecs[16] = '{8'd0, 32'd1024,     32'd0,        4'h0, 8'd3, 32'd0};
        vecs[17] = '{8'd1, 32'd1029,     32'h77,       4'hF, 8'd3, 32'd0};
        vecs[18] = '{8'd2, 32'h80000005, 32'h99,       4'hF, 8'd3, 32'd0};
        vecs[19] = '{8'd0, 32'd5,        32'd0,        4'h0, 8'd0, 32'hDEADBEAA};

        // Reset with a request presented; it must not be taken.
        rst                    = 1'b1;
        bus.endpoint_rsp_ready = 1'b1;
        bus.mc_req             = mk_req(8'd1, 32'd100, 32'h1, 4'hF, 8'h0);
        bus.mc_req_v           = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", bus.mc_req_ready, 0);
        check("rst_v", bus.endpoint_rsp_v, 0);
        check("rst_rsp", bus.endpoint_rsp, 0);
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.mc_req_v = 1'b0;
        @(negedge clk);
        check("post_rst_ready", bus.mc_req_ready, 1);
        check("post_rst_req_cnt", req_count, 0);
        check("post_rst_err_cnt", err_count, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].data,
                    vecs[i].mask, 8'(i), vecs[i].exp_type, vecs[i].exp_data);
        end
        @(negedge clk);
        check("tbl_req_cnt", req_count, 32'(exp_req));
        check("tbl_err_cnt", err_count, 32'(exp_err));
        @(posedge clk); #1;

        // Back-to-back AMOs on one address, each seeing the previous write.
        bus.mc_req   = mk_req(8'd3, 32'd7, 32'd5, 4'h0, 8'h40);
        bus.mc_req_v = 1'b1;
        @(negedge clk);
        check("amo_ready0", bus.mc_req_ready, 1);
        @(posedge clk); #1;
        bus.mc_req = mk_req(8'd0, 32'd7, 32'd0, 4'h0, 8'h41);
        @(negedge clk);
        check("amoadd_rsp", bus.endpoint_rsp, mk_rsp(8'd0, 32'd10, 8'h40));
        check("amo_ready1", bus.mc_req_ready, 1);
        @(posedge clk); #1;
        bus.mc_req = mk_req(8'd2, 32'd7, 32'd1, 4'h0, 8'h42);
        @(negedge clk);
        check("amo_load_rsp", bus.endpoint_rsp, mk_rsp(8'd0, 32'd15, 8'h41));
        @(posedge clk); #1;
        bus.mc_req_v = 1'b0;
        exp_req += 3;
        @(negedge clk);
        check("amoswap_rsp", bus.endpoint_rsp, mk_rsp(8'd0, 32'd15, 8'h42));
        @(posedge clk); #1;
        run_vec("amo_after", 8'd0, 32'd7, 32'd0, 4'h0, 8'h43, 8'd0, 32'd1);

        // Backpressure: only two responses can queue while the sink stalls.
        q_req[0] = mk_req(8'd0, 32'd5,    32'd0, 4'h0, 8'h50);
        q_req[1] = mk_req(8'd0, 32'd9,    32'd0, 4'h0, 8'h51);
        q_req[2] = mk_req(8'd0, 32'd7,    32'd0, 4'h0, 8'h52);
        q_req[3] = mk_req(8'd0, 32'd1023, 32'd0, 4'h0, 8'h53);
        q_rsp[0] = mk_rsp(8'd0, 32'hDEADBEAA, 8'h50);
        q_rsp[1] = mk_rsp(8'd0, 32'hFF22FF44, 8'h51);
        q_rsp[2] = mk_rsp(8'd0, 32'd1,        8'h52);
        q_rsp[3] = mk_rsp(8'd0, 32'h12345678, 8'h53);
        bus.endpoint_rsp_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            bus.mc_req   = q_req[idx];
            bus.mc_req_v = 1'b1;
            @(negedge clk);
            rdy = bus.mc_req_ready;
            if (c >= 1) check($sformatf("bp_head%0d", c), bus.endpoint_rsp, q_rsp[0]);
            @(posedge clk); #1;
            if (rdy) idx++;
        end
        check("bp_accepted", 128'(idx), 2);
        @(negedge clk);
        check("bp_ready", bus.mc_req_ready, 0);
        @(posedge clk); #1;

        bus.endpoint_rsp_ready = 1'b1;
        outn = 0;
        for (int c = 0; c < 20 && outn < 4; c++) begin
            drove = (idx < 4);
            if (drove) bus.mc_req = q_req[idx];
            bus.mc_req_v = drove;
            @(negedge clk);
            rdy = bus.mc_req_ready;
            if (bus.endpoint_rsp_v) begin
                check($sformatf("drain%0d", outn), bus.endpoint_rsp, q_rsp[outn]);
                outn++;
            end
            @(posedge clk); #1;
            if (rdy && drove) idx++;
        end
        bus.mc_req_v = 1'b0;
        exp_req += 4;
        check("drain_count", 128'(outn), 4);
        check("drain_accepted", 128'(idx), 4);
        @(negedge clk);
        check("bp_req_cnt", req_count, 32'(exp_req));
        @(posedge clk); #1;

        // Reset with two responses queued and a store arriving as reset rises.
        bus.endpoint_rsp_ready = 1'b0;
        bus.mc_req   = mk_req(8'd1, 32'd20, 32'hCAFEF00D, 4'hF, 8'h60);
        bus.mc_req_v = 1'b1;
        @(posedge clk); #1;
        bus.mc_req = mk_req(8'd0, 32'd5, 32'd0, 4'h0, 8'h61);
        @(posedge clk); #1;
        bus.mc_req = mk_req(8'd1, 32'd5, 32'd0, 4'hF, 8'h62);
        rst        = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", bus.mc_req_ready, 0);
        check("mid_rst_queued_v", bus.endpoint_rsp_v, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_v", bus.endpoint_rsp_v, 0);
        check("mid_rst_rsp", bus.endpoint_rsp, 0);
        check("mid_rst_req_cnt", req_count, 0);
        check("mid_rst_err_cnt", err_count, 0);
        @(posedge clk); #1;
        rst                    = 1'b0;
        bus.mc_req_v           = 1'b0;
        bus.endpoint_rsp_ready = 1'b1;
        exp_req = 0;
        exp_err = 0;
        @(negedge clk);
        check("after_rst_ready", bus.mc_req_ready, 1);
        @(posedge clk); #1;
        run_vec("retain_a5",  8'd0, 32'd5,  32'd0, 4'h0, 8'h70, 8'd0, 32'hDEADBEAA);
        run_vec("retain_a20", 8'd0, 32'd20, 32'd0, 4'h0, 8'h71, 8'd0, 32'hCAFEF00D);
        @(negedge clk);
        check("final_req_cnt", req_count, 32'(exp_req));
        check("final_err_cnt", err_count, 32'(exp_err));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
